sample_capture_scheduler: RTL and testbench

SAMPLE_CAPTURE_SCHEDULER -- requirements
Module: sample_capture_scheduler

---
 rtl/sample_capture_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_sample_capture_scheduler.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_capture_scheduler.sv
// Capture scheduler: buffers sampler words into SDRAM, then streams them back out over UART.
// Optional dump header (0xAA, 0x55, 24-bit written count) is compiled in with CAPTURE_HEADER_EN.
module sample_capture_scheduler #(
  parameter int unsigned CAPTURE_WORDS = 4096,
  parameter int unsigned FIFO_DEPTH    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        dump,
  output logic        sampler_start,
  input  logic        sampler_new_data,
  input  logic [21:0] sampler_data_out,
  output logic        mem_cmd_enable,
  output logic        mem_cmd_wr,
  output logic [22:0] mem_cmd_address,
  output logic [31:0] mem_cmd_data,
  input  logic        mem_cmd_ready,
  input  logic [31:0] mem_data_out,
  input  logic        mem_data_valid,
  output logic [7:0]  tx_byte,
  output logic        tx_en,
  input  logic        tx_ready,
  output logic        busy,
  output logic        overflow,
  output logic        done
);

  localparam int unsigned AW = 23;
  localparam int unsigned DW = 32;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
`ifdef CAPTURE_HEADER_EN
  localparam int unsigned TXW = 40;
`else
  localparam int unsigned TXW = 32;
`endif

  typedef enum logic [2:0] {
    IDLE, CAP_RUN, CAP_DRAIN, DUMP_CMD, DUMP_WAIT, DUMP_TX, FINISH
  } state_t;

  state_t state, state_nx;

  logic [DW-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  fifo_cnt;
  logic [AW-1:0]  sample_cnt, wr_addr, rd_addr;
  logic [TXW-1:0] tx_buf;
  logic [2:0]     tx_left;
  logic           tx_dead;
`ifdef CAPTURE_HEADER_EN
  logic           hdr_phase;
`endif

  logic fifo_full_c, fifo_empty_c, push_c, accept_c, pop_c, cap_last_c;
  logic tx_fire_c, tx_last_c, rd_more_c;

  assign fifo_full_c  = (fifo_cnt == CW'(FIFO_DEPTH));
  assign fifo_empty_c = (fifo_cnt == '0);
  assign push_c       = (state == CAP_RUN) && sampler_new_data && !fifo_full_c;
  assign accept_c     = mem_cmd_enable && mem_cmd_ready;
  assign pop_c        = accept_c && mem_cmd_wr;
  assign cap_last_c   = push_c && (sample_cnt == AW'(CAPTURE_WORDS - 1));
  // A byte goes out only after the post-pulse dead cycle has elapsed.
  assign tx_fire_c    = (state == DUMP_TX) && !tx_en && !tx_dead && tx_ready;
  assign tx_last_c    = tx_en && (tx_left == 3'd1);
  assign rd_more_c    = ((rd_addr + AW'(1)) < wr_addr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = CAP_RUN;
        else if (dump) begin
          if (wr_addr == '0) state_nx = FINISH;
`ifdef CAPTURE_HEADER_EN
          else               state_nx = DUMP_TX;
`else
          else               state_nx = DUMP_CMD;
`endif
        end
      end
      CAP_RUN:   if (cap_last_c) state_nx = CAP_DRAIN;
      CAP_DRAIN: if (fifo_empty_c && !mem_cmd_enable) state_nx = FINISH;
      DUMP_CMD:  if (accept_c) state_nx = DUMP_WAIT;
      DUMP_WAIT: if (mem_data_valid) state_nx = DUMP_TX;
      DUMP_TX: begin
        if (tx_last_c) begin
`ifdef CAPTURE_HEADER_EN
          if (hdr_phase) state_nx = DUMP_CMD;
          else           state_nx = rd_more_c ? DUMP_CMD : FINISH;
`else
          state_nx = rd_more_c ? DUMP_CMD : FINISH;
`endif
        end
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Sample buffer storage; occupancy and pointers live in the reset domain below.
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr] <= {sample_cnt[9:0], sampler_data_out};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      sampler_start   <= 1'b0;
      overflow        <= 1'b0;
      mem_cmd_enable  <= 1'b0;
      mem_cmd_wr      <= 1'b0;
      mem_cmd_address <= '0;
      mem_cmd_data    <= '0;
      tx_byte         <= '0;
      tx_en           <= 1'b0;
      tx_dead         <= 1'b0;
      tx_buf          <= '0;
      tx_left         <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_cnt        <= '0;
      sample_cnt      <= '0;
      wr_addr         <= '0;
      rd_addr         <= '0;
`ifdef CAPTURE_HEADER_EN
      hdr_phase       <= 1'b0;
`endif
    end else begin
      busy          <= (state_nx != IDLE);
      done          <= (state_nx == FINISH);
      sampler_start <= (state_nx == CAP_RUN);
      tx_en         <= tx_fire_c;
      tx_dead       <= (state == DUMP_TX) && tx_en;

      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PW'(1);
      if (push_c && !pop_c)      fifo_cnt <= fifo_cnt + CW'(1);
      else if (pop_c && !push_c) fifo_cnt <= fifo_cnt - CW'(1);

      if (state == IDLE && start) begin
        sample_cnt <= '0;
        wr_addr    <= '0;
        overflow   <= 1'b0;
      end else begin
        if (push_c) sample_cnt <= sample_cnt + AW'(1);
        if (state == CAP_RUN && sampler_new_data && fifo_full_c) overflow <= 1'b1;
        if (pop_c) wr_addr <= wr_addr + AW'(1);
      end

      // One command in flight; enable drops for a cycle after every acceptance.
      if (accept_c) mem_cmd_enable <= 1'b0;
      else if (!mem_cmd_enable) begin
        if ((state == CAP_RUN || state == CAP_DRAIN) && !fifo_empty_c) begin
          mem_cmd_enable  <= 1'b1;
          mem_cmd_wr      <= 1'b1;
          mem_cmd_data    <= fifo_mem[rd_ptr];
          mem_cmd_address <= wr_addr;
        end else if (state == DUMP_CMD) begin
          mem_cmd_enable  <= 1'b1;
          mem_cmd_wr      <= 1'b0;
          mem_cmd_data    <= '0;
          mem_cmd_address <= rd_addr;
        end
      end

      if (state == IDLE && dump && !start) begin
        rd_addr <= '0;
`ifdef CAPTURE_HEADER_EN
        hdr_phase <= 1'b1;
        tx_buf    <= {8'hAA, 8'h55, 1'b0, wr_addr};
        tx_left   <= 3'd5;
`endif
      end

      if (state == DUMP_WAIT && mem_data_valid) begin
`ifdef CAPTURE_HEADER_EN
        hdr_phase <= 1'b0;
        tx_buf    <= {mem_data_out, 8'h00};
`else
        tx_buf    <= mem_data_out;
`endif
        tx_left   <= 3'd4;
      end

      if (tx_fire_c) tx_byte <= tx_buf[TXW-1 -: 8];

      if (state == DUMP_TX && tx_en) begin
        tx_buf  <= tx_buf << 8;
        tx_left <= tx_left - 3'd1;
      end

`ifdef CAPTURE_HEADER_EN
      if (tx_last_c && !hdr_phase) rd_addr <= rd_addr + AW'(1);
`else
      if (tx_last_c) rd_addr <= rd_addr + AW'(1);
`endif
    end
  end

endmodule

// File: tb/tb_sample_capture_scheduler.sv
// Scoreboard bench for sample_capture_scheduler: capture, overflow, dump, priority and reset cases.
module tb_sample_capture_scheduler;

  logic        clk;
  logic        rst;
  logic        start;
  logic        dump;
  logic        sampler_start;
  logic        sampler_new_data;
  logic [21:0] sampler_data_out;
  logic        mem_cmd_enable;
  logic        mem_cmd_wr;
  logic [22:0] mem_cmd_address;
  logic [31:0] mem_cmd_data;
  logic        mem_cmd_ready;
  logic [31:0] mem_data_out;
  logic        mem_data_valid;
  logic [7:0]  tx_byte;
  logic        tx_en;
  logic        tx_ready;
  logic        busy;
  logic        overflow;
  logic        done;

  sample_capture_scheduler #(.CAPTURE_WORDS(4), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .dump(dump),
    .sampler_start(sampler_start), .sampler_new_data(sampler_new_data),
    .sampler_data_out(sampler_data_out),
    .mem_cmd_enable(mem_cmd_enable), .mem_cmd_wr(mem_cmd_wr),
    .mem_cmd_address(mem_cmd_address), .mem_cmd_data(mem_cmd_data),
    .mem_cmd_ready(mem_cmd_ready), .mem_data_out(mem_data_out),
    .mem_data_valid(mem_data_valid), .tx_byte(tx_byte), .tx_en(tx_en),
    .tx_ready(tx_ready), .busy(busy), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;
  initial clk = 1'b0;

  typedef struct {
    logic [22:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_wr[$];
  logic [22:0] exp_rd[$];
  logic [7:0]  exp_tx[$];
  int          checks;
  int          fails;
  int          done_cnt;
  int          rd_delay;
  logic [22:0] rd_a;
  logic        prev_tx_en;
  logic        prev_done;
  logic [31:0] mem_model [16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [22:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_wr.push_back(e);
  endtask

  task automatic push_word_bytes(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_tx.push_back(w[b*8 +: 8]);
  endtask

  task automatic send_sample(input logic [21:0] d);
    sampler_new_data = 1'b1;
    sampler_data_out = d;
    cyc(1);
    sampler_new_data = 1'b0;
    cyc(3);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      cyc(1);
      if (done_cnt != d0) break;
    end
    check(name, 64'(done_cnt - d0), 64'd1);
  endtask

  // Memory responder, UART ready toggling and output monitor, all sampled mid-cycle.
  task automatic monitor_loop();
    wr_t e;
    forever begin
      @(negedge clk);
      mem_data_valid = 1'b0;
      if (rd_delay != 0) begin
        rd_delay--;
        if (rd_delay == 0) begin
          mem_data_valid = 1'b1;
          mem_data_out   = mem_model[rd_a[3:0]];
        end
      end
      tx_ready = ~tx_ready;
      if (mem_cmd_enable && mem_cmd_ready) begin
        if (mem_cmd_wr) begin
          mem_model[mem_cmd_address[3:0]] = mem_cmd_data;
          check("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
          if (exp_wr.size() != 0) begin
            e = exp_wr.pop_front();
            check("wr_addr", 64'(mem_cmd_address), 64'(e.a));
            check("wr_data", 64'(mem_cmd_data), 64'(e.d));
          end
        end else begin
          rd_delay = 2;
          rd_a     = mem_cmd_address;
          check("rd_expected", 64'(exp_rd.size() != 0), 64'd1);
          if (exp_rd.size() != 0) check("rd_addr", 64'(mem_cmd_address), 64'(exp_rd.pop_front()));
        end
      end
      if (tx_en) begin
        check("tx_gap", 64'(prev_tx_en), 64'd0);
        check("tx_expected", 64'(exp_tx.size() != 0), 64'd1);
        if (exp_tx.size() != 0) check("tx_byte", 64'(tx_byte), 64'(exp_tx.pop_front()));
      end
      prev_tx_en = tx_en;
      if (done) begin
        done_cnt++;
        check("done_width", 64'(prev_done), 64'd0);
      end
      prev_done = done;
    end
  endtask

  initial begin
    checks = 0; fails = 0; done_cnt = 0; rd_delay = 0; rd_a = '0;
    prev_tx_en = 1'b0; prev_done = 1'b0;
    rst = 1'b0; start = 1'b0; dump = 1'b0;
    sampler_new_data = 1'b0; sampler_data_out = '0;
    mem_cmd_ready = 1'b0; mem_data_out = '0; mem_data_valid = 1'b0; tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem_model[i] = '0;
    fork
      monitor_loop();
    join_none

    cyc(3);
    check("reset_ctrl", 64'({busy, done, overflow, sampler_start, mem_cmd_enable, mem_cmd_wr, tx_en}), 64'd0);
    check("reset_bus", 64'(|{mem_cmd_address, mem_cmd_data, tx_byte}), 64'd0);
    rst = 1'b1;
    cyc(2);

    // Basic capture; start and dump together, stray dump mid-capture.
    mem_cmd_ready = 1'b1;
    push_wr(23'd0, 32'h0000_0001);
    push_wr(23'd1, 32'h0040_0002);
    push_wr(23'd2, 32'h0080_0003);
    push_wr(23'd3, 32'h00C0_0004);
    start = 1'b1; dump = 1'b1;
    cyc(1);
    start = 1'b0; dump = 1'b0;
    check("cap_busy", 64'(busy), 64'd1);
    check("cap_sampler_start", 64'(sampler_start), 64'd1);
    send_sample(22'h000001);
    dump = 1'b1;
    cyc(1);
    dump = 1'b0;
    send_sample(22'h000002);
    send_sample(22'h000003);
    send_sample(22'h000004);
    check("cap_sampler_start_off", 64'(sampler_start), 64'd0);
    wait_done("cap_done", 200);
    cyc(1);
    check("cap_idle", 64'({busy, overflow}), 64'd0);
    check("cap_writes_left", 64'(exp_wr.size()), 64'd0);

    // Dump of the 4-word capture.
`ifdef CAPTURE_HEADER_EN
    exp_tx.push_back(8'hAA);
    exp_tx.push_back(8'h55);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h04);
`endif
    for (int i = 0; i < 4; i++) exp_rd.push_back(23'(i));
    push_word_bytes(32'h0000_0001);
    push_word_bytes(32'h0040_0002);
    push_word_bytes(32'h0080_0003);
    push_word_bytes(32'h00C0_0004);
    dump = 1'b1;
    cyc(1);
    dump = 1'b0;
    check("dump_busy", 64'(busy), 64'd1);
    wait_done("dump_done", 600);
    check("dump_tx_left", 64'(exp_tx.size()), 64'd0);
    check("dump_rd_left", 64'(exp_rd.size()), 64'd0);
    cyc(2);

    // Overflow with the SDRAM stalled.
    mem_cmd_ready = 1'b0;
    push_wr(23'd0, 32'h0000_0011);
    push_wr(23'd1, 32'h0040_0022);
    pulse_start();
    send_sample(22'h000011);
    send_sample(22'h000022);
    check("ovf_clear_before_drop", 64'(overflow), 64'd0);
    send_sample(22'h000033);
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_writes_held", 64'(exp_wr.size()), 64'd2);
    mem_cmd_ready = 1'b1;
    cyc(8);
    check("ovf_two_writes", 64'(exp_wr.size()), 64'd0);
    push_wr(23'd2, 32'h0080_0044);
    push_wr(23'd3, 32'h00C0_0055);
    send_sample(22'h000044);
    send_sample(22'h000055);
    wait_done("ovf_done", 200);
    check("ovf_sticky", 64'(overflow), 64'd1);
    cyc(2);

    // Reset in the middle of a pending write, then an empty dump.
    mem_cmd_ready = 1'b0;
    pulse_start();
    check("rst_ovf_cleared", 64'(overflow), 64'd0);
    send_sample(22'h000077);
    check("rst_mid_write", 64'(mem_cmd_enable && mem_cmd_wr), 64'd1);
    rst = 1'b0;
    #1;
    check("rst_async_ctrl", 64'({busy, done, overflow, sampler_start, mem_cmd_enable, mem_cmd_wr, tx_en}), 64'd0);
    check("rst_async_bus", 64'(|{mem_cmd_address, mem_cmd_data, tx_byte}), 64'd0);
    cyc(2);
    rst = 1'b1;
    mem_cmd_ready = 1'b1;
    cyc(1);
    dump = 1'b1;
    cyc(1);
    dump = 1'b0;
    wait_done("empty_dump_done", 4);
    cyc(6);
    check("empty_dump_idle", 64'({busy, mem_cmd_enable, tx_en}), 64'd0);
    check("queues_empty", 64'(exp_wr.size() + exp_rd.size() + exp_tx.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
